// File: rtl/legv8_pkg.sv
// Shared LEGv8 types and widths for the unified instruction/data memory arbiter.
package legv8_pkg;

  localparam int WORD      = 64;
  localparam int INST_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_DATA = 1'b0,
    REQ_INST = 1'b1
  } req_id_e;

endpackage

// File: rtl/unified_mem_arbiter_prio.sv
// Grant choice between fetch and load/store, with a bounded data-streak counter
// so that a pending fetch cannot be starved by back-to-back data accesses.
module arb_priority
  import legv8_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    inst_req_i,
  input  logic    data_req_i,
  input  logic    grant_en_i,
  output req_id_e grant_id_o
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  logic [SW-1:0] streak_q, streak_d;

  always_comb begin
    grant_id_o = REQ_DATA;
    if (inst_req_i && (!data_req_i || streak_q == SW'(MAX_DATA_STREAK)))
      grant_id_o = REQ_INST;

    streak_d = streak_q;
    if (grant_en_i) begin
      // Only data grants that overtake a waiting fetch count toward the streak.
      if (grant_id_o == REQ_INST || !inst_req_i)
        streak_d = '0;
      else if (streak_q != SW'(MAX_DATA_STREAK))
        streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) streak_q <= '0;
    else         streak_q <= streak_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory arbiter: serialises IF fetches and MEM loads/stores
// onto a fixed-latency backend, one access per MEM_LAT+3 cycles.
module unified_mem_arbiter
  import legv8_pkg::*;
#(
  parameter int ADDR_W          = WORD,
  parameter int DATA_W          = WORD,
  parameter int INST_W          = INST_SIZE,
  parameter int MEM_LAT         = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ack,
  output logic [INST_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e        state_q, state_d;
  req_id_e           id_q, id_d, grant_id;
  logic [LW-1:0]     lat_q, lat_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              iack_q, iack_d, dack_q, dack_d;
  logic [INST_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              grant_en;
  logic              unused_addr_bits;

  assign grant_en         = (state_q == IDLE) && (inst_req || data_req);
  assign unused_addr_bits = ^addr_q[1:0];

  arb_priority #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .inst_req_i(inst_req),
    .data_req_i(data_req),
    .grant_en_i(grant_en),
    .grant_id_o(grant_id)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    lat_d    = lat_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_en) begin
          id_d    = grant_id;
          state_d = ISSUE;
          if (grant_id == REQ_INST) begin
            we_d   = 1'b0;
            addr_d = inst_addr;
          end else begin
            we_d    = data_we;
            addr_d  = data_addr;
            wdata_d = data_wdata;
          end
        end
      end
      ISSUE: begin
        lat_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Last WAIT cycle is exactly MEM_LAT cycles after the mem_en strobe.
        if (lat_q == LW'(MEM_LAT - 1)) begin
          state_d = RESP;
          if (id_q == REQ_INST) begin
            iack_d   = 1'b1;
            irdata_d = addr_q[2] ? mem_rdata[INST_W +: INST_W] : mem_rdata[INST_W-1:0];
          end else begin
            dack_d = 1'b1;
            if (!we_q) drdata_d = mem_rdata;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      id_q     <= REQ_DATA;
      lat_q    <= '0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      lat_q    <= lat_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign mem_en     = (state_q == ISSUE);
  assign mem_we     = mem_en & we_q;
  assign mem_addr   = mem_en ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign mem_wdata  = mem_en ? wdata_q : '0;
  assign busy       = (state_q != IDLE);
  assign inst_ack   = iack_q;
  assign data_ack   = dack_q;
  assign inst_rdata = irdata_q;
  assign data_rdata = drdata_q;
  assign if_stall   = inst_req & ~iack_q;
  assign mem_stall  = data_req & ~dack_q;

endmodule
